// File: rtl/count_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// count_sweep_ctrl
//   Sweeps an owned counter between two latched bounds [lo, hi] in one of four
//   modes: single up, single down, ping-pong for N round trips, or continuous
//   ping-pong. All outputs are registered.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst    : synchronous active-high reset
//   start  : sweep request, sampled only while idle
//   mode   : 0 single up, 1 single down, 2 ping-pong N trips, 3 continuous
//   lo/hi  : unsigned sweep bounds (latched at start)
//   trips  : round-trip count for mode 2 (0 behaves as 1)
//   abort  : terminate an active sweep without a done pulse
//   count  : counter value
//   dir    : 1 counting up, 0 counting down
//   busy   : high while sweeping (UP/DOWN)
//   done   : one-cycle pulse on normal completion
//   err    : one-cycle pulse when a start with lo > hi is rejected
// ---------------------------------------------------------------------------
module count_sweep_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [3:0]       trips,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_PP_N = 2'd2;
  localparam logic [1:0] MODE_PP_C = 2'd3;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [3:0]       rem_q, rem_d;

  // Next-state and next-output computation for the sweep FSM.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mode_d  = mode_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    rem_d   = rem_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (lo > hi) begin
            // Rejected: count and dir are left untouched.
            err_d = 1'b1;
          end else begin
            mode_d = mode;
            lo_d   = lo;
            hi_d   = hi;
            rem_d  = (trips == 4'd0) ? 4'd1 : trips;
            busy_d = 1'b1;
            if (mode == MODE_DOWN) begin
              state_d = ST_DOWN;
              count_d = hi;
              dir_d   = 1'b0;
            end else begin
              state_d = ST_UP;
              count_d = lo;
              dir_d   = 1'b1;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_UP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (count_q < hi_q) begin
          count_d = count_q + ONE;
          busy_d  = 1'b1;
        end else if ((mode_q == MODE_PP_N) || (mode_q == MODE_PP_C)) begin
          // Turn around at the top; a degenerate range holds its value.
          state_d = ST_DOWN;
          dir_d   = 1'b0;
          count_d = (lo_q == hi_q) ? hi_q : (hi_q - ONE);
          busy_d  = 1'b1;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      ST_DOWN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (count_q > lo_q) begin
          count_d = count_q - ONE;
          busy_d  = 1'b1;
        end else begin
          case (mode_q)
            MODE_PP_N: begin
              // One round trip finishes each time the bottom is reached.
              rem_d = (rem_q == 4'd0) ? 4'd0 : (rem_q - 4'd1);
              if (rem_q <= 4'd1) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_UP;
                dir_d   = 1'b1;
                count_d = (lo_q == hi_q) ? lo_q : (lo_q + ONE);
                busy_d  = 1'b1;
              end
            end
            MODE_PP_C: begin
              state_d = ST_UP;
              dir_d   = 1'b1;
              count_d = (lo_q == hi_q) ? lo_q : (lo_q + ONE);
              busy_d  = 1'b1;
            end
            MODE_UP, MODE_DOWN: begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
            default: begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          endcase
        end
      end

      ST_DONE: begin
        // Start and abort are deliberately ignored here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= {WIDTH{1'b0}};
      dir_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mode_q  <= 2'd0;
      lo_q    <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      rem_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rem_q   <= rem_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_count_sweep_ctrl
//   Self-checking bench: a vector table, hand-written multi-cycle sequences,
//   and a randomized run against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_count_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [7:0] lo;
  logic [7:0] hi;
  logic [3:0] trips;
  logic       abort;
  logic [7:0] count;
  logic       dir;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  count_sweep_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .lo(lo), .hi(hi),
    .trips(trips), .abort(abort), .count(count), .dir(dir), .busy(busy),
    .done(done), .err(err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] trips;
    logic       abort;
    logic [7:0] e_count;
    logic       e_dir;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t vecs[14];

  // Reference model state
  int   m_phase;
  int   m_count;
  logic m_dir, m_busy, m_done, m_err;
  int   m_mode, m_lo, m_hi;
  int   qc[$];
  logic qd[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int ec, input logic ed,
                     input logic eb, input logic edn, input logic ee);
    checks++;
    if (count !== ec[7:0] || dir !== ed || busy !== eb || done !== edn || err !== ee) begin
      errors++;
      $display("FAIL %s @%0t: got count=%0d dir=%0b busy=%0b done=%0b err=%0b, expected count=%0d dir=%0b busy=%0b done=%0b err=%0b",
               nm, $time, count, dir, busy, done, err, ec, ed, eb, edn, ee);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [1:0] md,
                       input logic [7:0] l, input logic [7:0] h,
                       input logic [3:0] t, input logic a);
    rst = r; start = s; mode = md; lo = l; hi = h; trips = t; abort = a;
  endtask

  // One round trip: up segment then down segment back to lo.
  task automatic push_trip(input bit first);
    int s;
    s = (first || m_lo == m_hi) ? m_lo : m_lo + 1;
    for (int v = s; v <= m_hi; v++) begin qc.push_back(v); qd.push_back(1'b1); end
    if (m_lo == m_hi) begin
      qc.push_back(m_lo); qd.push_back(1'b0);
    end else begin
      for (int v = m_hi - 1; v >= m_lo; v--) begin qc.push_back(v); qd.push_back(1'b0); end
    end
  endtask

  task automatic pop_model();
    m_count = qc.pop_front();
    m_dir   = qd.pop_front();
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int t;
    if (rst) begin
      m_phase = 0; m_count = 0; m_dir = 1'b1;
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
      qc.delete(); qd.delete();
    end else if (m_phase == 0) begin
      m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0;
      if (start) begin
        if (lo > hi) begin
          m_err = 1'b1;
        end else begin
          m_mode = mode; m_lo = lo; m_hi = hi;
          qc.delete(); qd.delete();
          case (m_mode)
            0: for (int v = m_lo; v <= m_hi; v++) begin qc.push_back(v); qd.push_back(1'b1); end
            1: for (int v = m_hi; v >= m_lo; v--) begin qc.push_back(v); qd.push_back(1'b0); end
            2: begin
              t = (trips == 4'd0) ? 1 : int'(trips);
              for (int k = 0; k < t; k++) push_trip(k == 0);
            end
            default: push_trip(1'b1);
          endcase
          pop_model();
          m_busy = 1'b1;
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (abort) begin
        m_phase = 0; m_busy = 1'b0;
      end else begin
        if (qc.size() == 0 && m_mode == 3) push_trip(1'b0);
        if (qc.size() == 0) begin
          m_phase = 2; m_busy = 1'b0; m_done = 1'b1;
        end else begin
          pop_model();
        end
      end
    end else begin
      m_phase = 0; m_done = 1'b0;
    end
  endtask

  initial begin
    int ec[$];
    logic ed[$];

    drive(1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 4'd0, 1'b0);

    //           rst   start mode  lo      hi      trips abort  cnt    dir   busy  done  err
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 8'd0,   8'd0,   4'd0, 1'b0,  8'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 8'd0,   8'd0,   4'd0, 1'b0,  8'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 8'd3,   8'd5,   4'd0, 1'b0,  8'd3,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'd1, 8'd0,   8'd200, 4'd0, 1'b0,  8'd4,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 8'd0,   8'd1,   4'd0, 1'b0,  8'd5,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 8'd0,   8'd1,   4'd0, 1'b0,  8'd5,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 8'd0,   8'd1,   4'd0, 1'b1,  8'd5,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 8'd0,   8'd1,   4'd0, 1'b0,  8'd5,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 8'd9,   8'd4,   4'd0, 1'b0,  8'd5,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 8'd9,   8'd4,   4'd0, 1'b0,  8'd5,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 8'd0,   8'd0,   4'd0, 1'b1,  8'd5,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'd0, 8'd10,  8'd10,  4'd0, 1'b0,  8'd10, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 8'd10,  8'd10,  4'd0, 1'b1,  8'd10, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 8'd10,  8'd10,  4'd0, 1'b0,  8'd10, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].mode, vecs[i].lo, vecs[i].hi,
            vecs[i].trips, vecs[i].abort);
      tick();
      chk($sformatf("vec%0d", i), int'(vecs[i].e_count), vecs[i].e_dir,
          vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err);
    end

    // Mode 2, lo=0 hi=2, two round trips
    ec = '{0, 1, 2, 1, 0, 1, 2, 1, 0};
    ed = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    drive(1'b0, 1'b1, 2'd2, 8'd0, 8'd2, 4'd2, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("pp2_step%0d", i), ec[i], ed[i], 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'd0, 1'b0);
    end
    tick(); chk("pp2_done", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); chk("pp2_idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mode 1 at the top of the range: no wrap
    drive(1'b0, 1'b1, 2'd1, 8'd250, 8'd255, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("down_step%0d", i), 255 - i, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'd0, 1'b0);
    end
    tick(); chk("down_done", 250, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); chk("down_idle", 250, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mode 3 with lo==hi, abort after five busy cycles
    drive(1'b0, 1'b1, 2'd3, 8'd7, 8'd7, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("cont_step%0d", i), 7, (i % 2 == 0), 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'd0, 1'b0);
    end
    abort = 1'b1;
    tick(); chk("cont_abort", 7, 1'b1, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    tick(); chk("cont_nodone", 7, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a mode 2 sweep, then a normal sweep
    drive(1'b0, 1'b1, 2'd2, 8'd20, 8'd30, 4'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rstmid_step%0d", i), 20 + i, 1'b1, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
    end
    rst = 1'b1; start = 1'b1;
    tick(); chk("rstmid_reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd0, 8'd1, 8'd2, 4'd0, 1'b0);
    tick(); chk("after_rst_0", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick(); chk("after_rst_1", 2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); chk("after_rst_done", 2, 1'b1, 1'b0, 1'b1, 1'b0);

    // Randomized run against the reference model
    rst = 1'b1;
    model_step();
    tick();
    chk("rand_reset", m_count, m_dir, m_busy, m_done, m_err);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [7:0] l;
      logic [7:0] h;
      l = 8'($urandom_range(0, 255));
      h = (l > 8'd249) ? 8'd255 : l + 8'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) begin
        h = l; l = l + 8'd1 + 8'($urandom_range(0, 3));
        if (l <= h) l = h + 8'd1;
        if (h == 8'd255) h = 8'd254;
      end
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), l, h, 4'($urandom_range(0, 3)),
            ($urandom_range(0, 39) == 0));
      model_step();
      tick();
      chk("rand", m_count, m_dir, m_busy, m_done, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sweep_ctrl.md
COUNT_SWEEP_CTRL -- requirements
Module: count_sweep_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, width of count, lo and hi.
REQ-002 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request a sweep; sampled only in IDLE.
REQ-005 Port: mode  input  2  0 = single up, 1 = single down, 2 = ping-pong N trips, 3 = ping-pong continuous.
REQ-006 Port: lo  input  WIDTH  lower sweep bound (unsigned).
REQ-007 Port: hi  input  WIDTH  upper sweep bound (unsigned).
REQ-008 Port: trips  input  4  round-trip count for mode 2; 0 is treated as 1.
REQ-009 Port: abort  input  1  terminate an active sweep.
REQ-010 Port: count  output  WIDTH  counter value.
REQ-011 Port: dir  output  1  1 = counting up, 0 = counting down.
REQ-012 Port: busy  output  1  high in UP and DOWN states.
REQ-013 Port: done  output  1  one-cycle pulse when a sweep completes normally.
REQ-014 Port: err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-015 The block SHALL implement the states IDLE, UP, DOWN and DONE, and SHALL own the count register.
REQ-016 In IDLE with start=1, the block SHALL latch mode, lo, hi and trips. Later input changes SHALL NOT affect the active sweep.
REQ-017 If lo>hi at start, the block SHALL pulse err for the next cycle, remain in IDLE, and leave count and dir unchanged.
REQ-018 On an accepted start, the next cycle SHALL show busy=1 with:
  - count=lo, dir=1, state UP for modes 0, 2 and 3;
  - count=hi, dir=0, state DOWN for mode 1.
REQ-019 In UP with count<hi, count SHALL increment by 1 per cycle. In DOWN with count>lo, count SHALL decrement by 1 per cycle. No modular wrap-around SHALL occur; count SHALL stay within [lo,hi].
REQ-020 In UP with count==hi:
  - mode 0 SHALL go to DONE;
  - modes 2 and 3 SHALL go to DOWN with dir=0 and next count=hi-1, or hold at hi if lo==hi.
REQ-021 In DOWN with count==lo:
  - mode 1 SHALL go to DONE;
  - mode 2 SHALL decrement the remaining-trips counter and go to DONE when it reaches 0, otherwise go to UP with next count=lo+1 (hold if lo==hi);
  - mode 3 SHALL always go to UP.
REQ-022 DONE SHALL last exactly one cycle with done=1, busy=0 and count holding the final value; the block SHALL then return to IDLE.
REQ-023 A start asserted in DONE SHALL be ignored.
REQ-024 abort in UP or DOWN SHALL move to IDLE on the next cycle with count and dir held and no done pulse. abort SHALL take priority over a simultaneous boundary transition.
REQ-025 abort in IDLE or DONE SHALL have no effect.
REQ-026 In IDLE, count and dir SHALL hold their last values, and busy, done and err SHALL be 0 except for the err pulse of REQ-017.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL enter IDLE with count=0, dir=1, busy=0, done=0, err=0 and remaining trips=0.
REQ-028 rst SHALL take priority over start, abort and every state transition, including mid-sweep.
REQ-029 rst SHALL have no asynchronous effect; outputs change only at clock edges.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - Mode 0, lo=3, hi=5, start one cycle -> count 3,4,5 with busy=1, then one cycle done=1 with count=5, then IDLE.
  - Mode 2, lo=0, hi=2, trips=2 -> count 0,1,2,1,0,1,2,1,0, dir toggling at 2 and 0, then a done pulse.
  - Mode 1, lo=250, hi=255 -> count 255 down to 250 with dir=0 and no wrap, then done.
  - Start with lo=9, hi=4 -> single err pulse, busy stays 0, count unchanged.
  - Mode 3, lo=hi=7, abort after 5 cycles -> count holds at 7 and dir alternates; IDLE next cycle with no done pulse.
  - rst asserted mid-sweep in mode 2 -> next cycle count=0, dir=1, busy=0; a subsequent start operates normally.
